uart_tx_arbiter: RTL

- Shares one 8-bit UART transmitter among NUM_REQ byte producers using round-robin arbitration with bounded bursts.
- Sits between the producer-side valid/ready interfaces and the transmitter's tx_start/tx_busy handshake. The transmitter is paced by the baud rate generator.
- Sequences each byte: grant, accept, launch, wait for the transmitter to go busy, then wait for it to go idle again.

---
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte producers.
// Bursts are bounded per grant; a silent transmitter is abandoned after a timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 ack_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] next_ptr;
  logic          win_found;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    owner_data;
  int            cand;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign owner_data = req_data[{owner, 3'b000} +: 8];
  assign next_ptr   = (owner == LAST) ? '0 : owner + 1'b1;
  assign req_ready  = (state == SEND) ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      to_cnt      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      ack_timeout <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      ack_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found && !tx_busy) begin
            owner     <= win_idx;
            grant     <= ONE << win_idx;
            burst_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          tx_data  <= owner_data;
          tx_start <= 1'b1;
          to_cnt   <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TMAX) begin
            // The accepted byte is dropped; the owner loses its turn
            ack_timeout <= 1'b1;
            rr_ptr      <= next_ptr;
            grant       <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (req_valid[owner] && burst_cnt < BMAX) begin
              burst_cnt <= burst_cnt + 1'b1;
              state     <= SEND;
            end else begin
              rr_ptr <= next_ptr;
              grant  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
